meta_stream_writer: RTL

//  Producer side of the metadata write port of meta_decode. Unpacks a DMA word stream of

---
 rtl/meta_stream_writer_if.sv | 26 ++
 rtl/meta_stream_writer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/meta_stream_writer_if.sv
// Stream-in / metadata-write-out bundle for meta_stream_writer.
// master: the writer (consumes the DMA stream, drives the metadata write port).
// slave : the surroundings (DMA read engine and meta_decode).
interface meta_stream_writer_if #(
   parameter int ADDR_W = 8
);
   logic [31:0]       s_tdata;
   logic              s_tvalid;
   logic              s_tready;
   logic              s_tlast;
   logic [31:0]       wr_data;
   logic [ADDR_W-1:0] wr_addr;
   logic [1:0]        wr_type;
   logic              wr_en;
   logic              wr_ready;

   modport master (
      input  s_tdata, s_tvalid, s_tlast, wr_ready,
      output s_tready, wr_data, wr_addr, wr_type, wr_en
   );

   modport slave (
      output s_tdata, s_tvalid, s_tlast, wr_ready,
      input  s_tready, wr_data, wr_addr, wr_type, wr_en
   );
endinterface

// File: rtl/meta_stream_writer.sv
// Unpacks header-prefixed DMA segments into metadata writes with
// auto-incrementing addresses, flags malformed segments and counts traffic.
// Header word: [31:30] type, [CNT_W+ADDR_W-1:CNT_W] base, [CNT_W-1:0] count.
module meta_stream_writer #(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8,
   parameter int PERF_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   meta_stream_writer_if.master  bus,
   output logic                  busy,
   output logic                  seg_done,
   output logic [3:0]            err_flags,
   input  logic                  err_clr,
   output logic [PERF_W-1:0]     perf_words,
   output logic [PERF_W-1:0]     perf_segments,
   output logic [PERF_W-1:0]     perf_stalls
);

   typedef enum logic [1:0] {
      ST_HDR     = 2'd0,
      ST_PAY     = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t            state_reg, state_next;

   // latched segment descriptor
   logic [1:0]        type_reg;
   logic [ADDR_W-1:0] base_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [CNT_W-1:0]  idx_reg;

   // pending write slot
   logic [31:0]       wr_data_reg;
   logic [ADDR_W-1:0] wr_addr_reg;
   logic [1:0]        wr_type_reg;
   logic              wr_en_reg;
   logic              last_good_reg;   // pending write closes a clean PAY segment

   logic              seg_done_reg;
   logic [3:0]        err_reg;
   logic [PERF_W-1:0] perf_words_reg, perf_segments_reg, perf_stalls_reg;

   logic              s_tready_int;
   logic              accept;
   logic              in_payload;
   logic              is_last;
   logic              write_fire;
   logic              seg_good;
   logic [CNT_W-1:0]  last_idx;
   logic [1:0]        hdr_type;
   logic [ADDR_W-1:0] hdr_base;
   logic [CNT_W-1:0]  hdr_cnt;
   logic [3:0]        err_new;

   assign hdr_type   = bus.s_tdata[31:30];
   assign hdr_base   = bus.s_tdata[CNT_W+ADDR_W-1:CNT_W];
   assign hdr_cnt    = bus.s_tdata[CNT_W-1:0];

   assign accept     = bus.s_tvalid && s_tready_int;
   assign in_payload = (state_reg == ST_PAY) || (state_reg == ST_DISCARD);
   assign last_idx   = cnt_reg - CNT_W'(1);
   assign is_last    = (idx_reg == last_idx);
   assign write_fire = wr_en_reg && bus.wr_ready;
   assign seg_good   = write_fire && last_good_reg;

   // malformed-segment detection on accepted words
   assign err_new[0] = accept && (state_reg == ST_HDR) && (hdr_cnt != '0) && (hdr_type == 2'b11);
   assign err_new[1] = accept && (state_reg == ST_HDR) && (hdr_cnt == '0);
   assign err_new[2] = accept && in_payload && bus.s_tlast && !is_last;
   assign err_new[3] = accept && in_payload && !bus.s_tlast && is_last;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_HDR;
      else     state_reg <= state_next;
   end

   // next-state logic: a segment ends on its last counted word or on tlast, whichever first
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_HDR: begin
            if (accept && hdr_cnt != '0)
               state_next = (hdr_type == 2'b11) ? ST_DISCARD : ST_PAY;
         end
         ST_PAY, ST_DISCARD: begin
            if (accept && (is_last || bus.s_tlast))
               state_next = ST_HDR;
         end
         default: state_next = ST_HDR;
      endcase
   end

   // FSM outputs: payload only stalls when the write slot is still occupied
   always_comb begin
      s_tready_int = 1'b1;
      case (state_reg)
         ST_PAY:  s_tready_int = !wr_en_reg || bus.wr_ready;
         default: s_tready_int = 1'b1;
      endcase
      busy = (state_reg != ST_HDR) || wr_en_reg;
   end

   // segment descriptor and payload index
   always_ff @(posedge clk) begin
      if (rst) begin
         type_reg <= '0;
         base_reg <= '0;
         cnt_reg  <= '0;
         idx_reg  <= '0;
      end else if (accept && state_reg == ST_HDR) begin
         if (hdr_cnt != '0) begin
            type_reg <= hdr_type;
            base_reg <= hdr_base;
            cnt_reg  <= hdr_cnt;
            idx_reg  <= '0;
         end
      end else if (accept && in_payload) begin
         idx_reg <= idx_reg + CNT_W'(1);
      end
   end

   // write slot: loaded by accepted payload, released by handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_reg     <= 1'b0;
         wr_data_reg   <= '0;
         wr_addr_reg   <= '0;
         wr_type_reg   <= '0;
         last_good_reg <= 1'b0;
      end else if (accept && state_reg == ST_PAY) begin
         wr_en_reg     <= 1'b1;
         wr_data_reg   <= bus.s_tdata;
         wr_addr_reg   <= base_reg + ADDR_W'(idx_reg);
         wr_type_reg   <= type_reg;
         last_good_reg <= is_last && bus.s_tlast;
      end else if (write_fire) begin
         wr_en_reg     <= 1'b0;
         last_good_reg <= 1'b0;
      end
   end

   // completion pulse and sticky error flags (a new error wins over err_clr)
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_done_reg <= 1'b0;
         err_reg      <= '0;
      end else begin
         seg_done_reg <= seg_good;
         err_reg      <= (err_clr ? 4'b0000 : err_reg) | err_new;
      end
   end

   // free-running wrapping traffic counters
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_words_reg    <= '0;
         perf_segments_reg <= '0;
         perf_stalls_reg   <= '0;
      end else begin
         if (write_fire)                  perf_words_reg    <= perf_words_reg + PERF_W'(1);
         if (seg_good)                    perf_segments_reg <= perf_segments_reg + PERF_W'(1);
         if (wr_en_reg && !bus.wr_ready)  perf_stalls_reg   <= perf_stalls_reg + PERF_W'(1);
      end
   end

   assign bus.s_tready  = s_tready_int;
   assign bus.wr_en     = wr_en_reg;
   assign bus.wr_data   = wr_data_reg;
   assign bus.wr_addr   = wr_addr_reg;
   assign bus.wr_type   = wr_type_reg;
   assign seg_done      = seg_done_reg;
   assign err_flags     = err_reg;
   assign perf_words    = perf_words_reg;
   assign perf_segments = perf_segments_reg;
   assign perf_stalls   = perf_stalls_reg;

endmodule
